// File: rtl/mlp_load_sequencer.sv
// rtl/mlp_load_sequencer.sv - streams one inference job from local SRAMs into the MLP accelerator load port
//
// Purpose: on an accepted start, hold the accelerator in reset, then issue one SRAM
// read per cycle (input rows interleaved with layer-0 weights, then layers 1..7),
// present each word as a load beat two cycles later, then wait for the result
// window and report done or timeout.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start_i                  job start pulse (honoured only when idle)
//   busy_o/done_o/timeout_o  job status
//   in_rd_*                  input SRAM read port (7-bit word address, 1-cycle latency)
//   w_rd_*                   weight SRAM read port (10-bit word address, 1-cycle latency)
//   acc_rst_n_o              accelerator reset
//   load_*/input_load_number_o/layer_number_o/weight_number_o  load beat and sideband
//   acc_result_valid_i       accelerator result valid
module mlp_load_sequencer #(
  parameter int N_LAYERS     = 8,
  parameter int ACC_RST_CYC  = 5,
  parameter int RESULT_BEATS = 128,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        in_rd_en_o,
  output logic [6:0]  in_rd_addr_o,
  input  logic [31:0] in_rd_data_i,
  output logic        w_rd_en_o,
  output logic [9:0]  w_rd_addr_o,
  input  logic [31:0] w_rd_data_i,
  output logic        acc_rst_n_o,
  output logic        load_en_o,
  output logic [31:0] load_payload_o,
  output logic        load_type_o,
  output logic [3:0]  input_load_number_o,
  output logic [2:0]  layer_number_o,
  output logic [2:0]  weight_number_o,
  input  logic        acc_result_valid_i
);

  localparam int          TOTAL_BEATS = 256 + (N_LAYERS - 1) * 128;
  localparam logic [10:0] END_IDX     = 11'(TOTAL_BEATS);
  localparam logic [12:0] ARST_END    = 13'(ACC_RST_CYC - 1);
  localparam logic [12:0] RES_END     = 13'(RESULT_BEATS - 1);
  localparam logic [12:0] TMO_END     = 13'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_ARST, S_LOAD, S_WAITV, S_RES, S_DONE
  } state_e;

  state_e      state_q;
  logic [12:0] cyc_q;
  logic [10:0] idx_q;

  logic        busy_q, done_q, timeout_q, acc_rst_n_q;
  logic        in_rd_en_q, w_rd_en_q;
  logic [6:0]  in_rd_addr_q;
  logic [9:0]  w_rd_addr_q;

  // Sideband stage 1 is aligned with the SRAM address, stage 2 with the SRAM data.
  logic        s1_vld_q, s1_type_q, s2_vld_q, s2_type_q;
  logic [3:0]  s1_row_q, s2_row_q;
  logic [2:0]  s1_layer_q, s1_w_q, s2_layer_q, s2_w_q;

  logic        load_en_q, load_type_q;
  logic [31:0] load_payload_q;
  logic [3:0]  row_q;
  logic [2:0]  layer_q, wnum_q;

  // Beat index decode. Below 256 each row is 8 input words then 8 layer-0 words;
  // above, index bits [6:0] are row/word and bits [10:7] minus one give the layer.
  logic        rd_type_d;
  logic [3:0]  rd_row_d;
  logic [2:0]  rd_layer_d, rd_w_d;
  logic        issue_d;

  always_comb begin
    if (idx_q < 11'd256) begin
      rd_type_d  = ~idx_q[3];
      rd_row_d   = idx_q[7:4];
      rd_layer_d = 3'd0;
    end else begin
      rd_type_d  = 1'b0;
      rd_row_d   = idx_q[6:3];
      rd_layer_d = 3'(idx_q[10:7] - 4'd1);
    end
    rd_w_d = idx_q[2:0];
  end

  // The first read is issued on the last reset cycle so it lands at start+6.
  assign issue_d = ((state_q == S_ARST) && (cyc_q == ARST_END)) ||
                   ((state_q == S_LOAD) && (idx_q != END_IDX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cyc_q          <= '0;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      acc_rst_n_q    <= 1'b0;
      in_rd_en_q     <= 1'b0;
      w_rd_en_q      <= 1'b0;
      in_rd_addr_q   <= '0;
      w_rd_addr_q    <= '0;
      s1_vld_q       <= 1'b0;
      s1_type_q      <= 1'b0;
      s1_row_q       <= '0;
      s1_layer_q     <= '0;
      s1_w_q         <= '0;
      s2_vld_q       <= 1'b0;
      s2_type_q      <= 1'b0;
      s2_row_q       <= '0;
      s2_layer_q     <= '0;
      s2_w_q         <= '0;
      load_en_q      <= 1'b0;
      load_type_q    <= 1'b0;
      load_payload_q <= '0;
      row_q          <= '0;
      layer_q        <= '0;
      wnum_q         <= '0;
    end else begin
      done_q     <= 1'b0;
      in_rd_en_q <= 1'b0;
      w_rd_en_q  <= 1'b0;
      s1_vld_q   <= 1'b0;

      s2_vld_q   <= s1_vld_q;
      s2_type_q  <= s1_type_q;
      s2_row_q   <= s1_row_q;
      s2_layer_q <= s1_layer_q;
      s2_w_q     <= s1_w_q;

      load_en_q <= s2_vld_q;
      if (s2_vld_q) begin
        load_payload_q <= s2_type_q ? in_rd_data_i : w_rd_data_i;
        load_type_q    <= s2_type_q;
        row_q          <= s2_row_q;
        layer_q        <= s2_layer_q;
        wnum_q         <= s2_w_q;
      end else begin
        // Row, layer and type hold their last values between jobs.
        load_payload_q <= '0;
        wnum_q         <= '0;
      end

      if (issue_d) begin
        in_rd_en_q <= rd_type_d;
        w_rd_en_q  <= ~rd_type_d;
        if (rd_type_d) in_rd_addr_q <= {rd_row_d, rd_w_d};
        else           w_rd_addr_q  <= {rd_layer_d, rd_row_d, rd_w_d};
        s1_vld_q   <= 1'b1;
        s1_type_q  <= rd_type_d;
        s1_row_q   <= rd_row_d;
        s1_layer_q <= rd_layer_d;
        s1_w_q     <= rd_w_d;
        idx_q      <= idx_q + 11'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            acc_rst_n_q <= 1'b0;
            cyc_q       <= '0;
            idx_q       <= '0;
            state_q     <= S_ARST;
          end
        end
        S_ARST: begin
          if (cyc_q == ARST_END) begin
            acc_rst_n_q <= 1'b1;
            state_q     <= S_LOAD;
          end else begin
            cyc_q <= cyc_q + 13'd1;
          end
        end
        S_LOAD: begin
          if (idx_q == END_IDX) begin
            cyc_q   <= '0;
            state_q <= S_WAITV;
          end
        end
        S_WAITV: begin
          if (acc_result_valid_i) begin
            cyc_q   <= '0;
            state_q <= S_RES;
          end else if (cyc_q == TMO_END) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cyc_q <= cyc_q + 13'd1;
          end
        end
        S_RES: begin
          if (cyc_q == RES_END) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cyc_q <= cyc_q + 13'd1;
          end
        end
        S_DONE: begin
          // Extra state keeps busy high during the done pulse and blocks a start there.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign timeout_o           = timeout_q;
  assign in_rd_en_o          = in_rd_en_q;
  assign in_rd_addr_o        = in_rd_addr_q;
  assign w_rd_en_o           = w_rd_en_q;
  assign w_rd_addr_o         = w_rd_addr_q;
  assign acc_rst_n_o         = acc_rst_n_q;
  assign load_en_o           = load_en_q;
  assign load_payload_o      = load_payload_q;
  assign load_type_o         = load_type_q;
  assign input_load_number_o = row_q;
  assign layer_number_o      = layer_q;
  assign weight_number_o     = wnum_q;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// tb/tb_mlp_load_sequencer.sv - directed self-checking bench for mlp_load_sequencer
module tb_mlp_load_sequencer;

  localparam int NB = 1152;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_i, acc_result_valid_i;
  logic [31:0] in_rd_data, w_rd_data;
  logic        busy_o, done_o, timeout_o, in_rd_en_o, w_rd_en_o, acc_rst_n_o;
  logic        load_en_o, load_type_o;
  logic [6:0]  in_rd_addr_o;
  logic [9:0]  w_rd_addr_o;
  logic [31:0] load_payload_o;
  logic [3:0]  input_load_number_o;
  logic [2:0]  layer_number_o, weight_number_o;

  mlp_load_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .timeout_o           (timeout_o),
    .in_rd_en_o          (in_rd_en_o),
    .in_rd_addr_o        (in_rd_addr_o),
    .in_rd_data_i        (in_rd_data),
    .w_rd_en_o           (w_rd_en_o),
    .w_rd_addr_o         (w_rd_addr_o),
    .w_rd_data_i         (w_rd_data),
    .acc_rst_n_o         (acc_rst_n_o),
    .load_en_o           (load_en_o),
    .load_payload_o      (load_payload_o),
    .load_type_o         (load_type_o),
    .input_load_number_o (input_load_number_o),
    .layer_number_o      (layer_number_o),
    .weight_number_o     (weight_number_o),
    .acc_result_valid_i  (acc_result_valid_i)
  );

  logic [31:0] in_mem [128];
  logic [31:0] w_mem  [1024];

  always @(posedge clk) begin
    if (in_rd_en_o) in_rd_data <= in_mem[in_rd_addr_o];
    if (w_rd_en_o)  w_rd_data  <= w_mem[w_rd_addr_o];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  int nbeats, ndone, done_cyc, first_beat, last_beat, nlow, first_low, vstart, s_cyc, to_cyc, vdly;
  bit busy_at_done, pulse_mode;
  logic [31:0] b_pay  [NB];
  logic        b_type [NB];
  logic [3:0]  b_row  [NB];
  logic [2:0]  b_lay  [NB];
  logic [2:0]  b_w    [NB];

  // One clock: sample outputs on the falling edge, then drive inputs for this cycle.
  task automatic do_cycle();
    int bi;
    @(negedge clk);
    cyc++;
    bi = -1;
    if (load_en_o) begin
      bi = nbeats;
      if (nbeats < NB) begin
        b_pay[nbeats]  = load_payload_o;
        b_type[nbeats] = load_type_o;
        b_row[nbeats]  = input_load_number_o;
        b_lay[nbeats]  = layer_number_o;
        b_w[nbeats]    = weight_number_o;
      end
      if (nbeats == 0) first_beat = cyc;
      last_beat = cyc;
      nbeats++;
      if (nbeats == NB && vdly >= 0) vstart = cyc + vdly;
    end
    if (done_o) begin
      ndone++;
      done_cyc = cyc;
      busy_at_done = busy_o;
    end
    if (!acc_rst_n_o && cyc > s_cyc) begin
      if (nlow == 0) first_low = cyc;
      nlow++;
    end
    if (timeout_o && to_cyc < 0) to_cyc = cyc;
    acc_result_valid_i = (vstart >= 0 && cyc >= vstart && cyc < vstart + 128);
    start_i = 1'b0;
    if (pulse_mode) begin
      if (bi == 3 || bi == 700) start_i = 1'b1;
      if (bi == 100) acc_result_valid_i = 1'b1;
      if (vstart >= 0 && cyc == vstart + 50) start_i = 1'b1;
    end
  endtask

  task automatic start_job();
    nbeats = 0; ndone = 0; nlow = 0; first_low = -1; vstart = -1; to_cyc = -1;
    done_cyc = -1; first_beat = -1; last_beat = -1; busy_at_done = 1'b0;
    s_cyc = cyc;
    start_i = 1'b1;
    do_cycle();
    check_eq("busy_after_start", busy_o, 1);
  endtask

  task automatic run_to_end(input int budget);
    int b;
    b = budget;
    while (ndone == 0 && to_cyc < 0 && b > 0) begin
      do_cycle();
      b--;
    end
    check_eq("job_end_reached", (ndone > 0 || to_cyc >= 0), 1);
  endtask

  function automatic void exp_beat(input int i, output logic t, output int r, output int l,
                                   output int w, output int a);
    if (i < 256) begin
      r = i / 16;
      w = i % 8;
      l = 0;
      t = ((i % 16) < 8);
      a = r * 8 + w;
    end else begin
      l = 1 + (i - 256) / 128;
      r = ((i - 256) % 128) / 8;
      w = i % 8;
      t = 1'b0;
      a = l * 128 + r * 8 + w;
    end
  endfunction

  task automatic check_stream();
    int mp, mt, mr, ml, mw, r, l, w, a;
    logic t;
    logic [31:0] ep;
    mp = 0; mt = 0; mr = 0; ml = 0; mw = 0;
    check_eq("beat_count", nbeats, NB);
    check_eq("first_beat_cyc", first_beat, s_cyc + 8);
    check_eq("last_beat_cyc", last_beat, s_cyc + 8 + NB - 1);
    check_eq("arst_low_cycles", nlow, 5);
    check_eq("arst_first_low", first_low, s_cyc + 1);
    for (int i = 0; i < NB; i++) begin
      if (i < nbeats) begin
        exp_beat(i, t, r, l, w, a);
        ep = t ? in_mem[a] : w_mem[a];
        if (b_pay[i] !== ep)       mp++;
        if (b_type[i] !== t)       mt++;
        if (b_row[i] !== 4'(r))    mr++;
        if (b_lay[i] !== 3'(l))    ml++;
        if (b_w[i] !== 3'(w))      mw++;
      end
    end
    check_eq("payload_mismatches", mp, 0);
    check_eq("type_mismatches", mt, 0);
    check_eq("row_mismatches", mr, 0);
    check_eq("layer_mismatches", ml, 0);
    check_eq("wnum_mismatches", mw, 0);
  endtask

  task automatic check_done();
    check_eq("done_count", ndone, 1);
    check_eq("done_cyc", done_cyc, last_beat + vdly + 129);
    check_eq("busy_at_done", busy_at_done, 1);
    do_cycle();
    check_eq("busy_after_done", busy_o, 0);
    check_eq("acc_rst_n_idle", acc_rst_n_o, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {busy_o, done_o, timeout_o, in_rd_en_o, in_rd_addr_o, w_rd_en_o, w_rd_addr_o,
                   acc_rst_n_o, load_en_o, load_type_o, input_load_number_o, layer_number_o,
                   weight_number_o, load_payload_o}, 64'd0);
  endtask

  initial begin
    int b;
    rst_n = 1'b0; start_i = 1'b0; acc_result_valid_i = 1'b0; pulse_mode = 1'b0; vdly = 20;
    s_cyc = 1 << 30; nbeats = 0; ndone = 0; nlow = 0; first_low = -1; vstart = -1;
    to_cyc = -1; done_cyc = -1; first_beat = -1; last_beat = -1; busy_at_done = 1'b0;
    for (int a = 0; a < 128; a++)  in_mem[a] = a;
    for (int a = 0; a < 1024; a++) w_mem[a] = a;

    repeat (3) do_cycle();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    do_cycle();
    do_cycle();

    // Basic job with address-valued SRAMs.
    start_job();
    run_to_end(1400);
    check_stream();
    check_eq("beat0_payload", b_pay[0], 0);
    check_eq("beat0_type", b_type[0], 1);
    check_eq("beat0_row", b_row[0], 0);
    check_eq("beat8_payload", b_pay[8], 0);
    check_eq("beat8_type", b_type[8], 0);
    check_eq("beat256_layer", b_lay[256], 1);
    check_eq("beat256_row", b_row[256], 0);
    check_eq("beat256_w", b_w[256], 0);
    check_eq("beat256_payload", b_pay[256], 128);
    check_eq("hold_layer", layer_number_o, 7);
    check_eq("hold_row", input_load_number_o, 15);
    check_eq("idle_wnum", weight_number_o, 0);
    check_eq("idle_payload", load_payload_o, 0);
    check_eq("idle_load_en", load_en_o, 0);
    check_done();

    // Back-to-back job with random SRAM contents, started the cycle after done.
    for (int a = 0; a < 128; a++)  in_mem[a] = $urandom;
    for (int a = 0; a < 1024; a++) w_mem[a] = $urandom;
    start_job();
    run_to_end(1400);
    check_stream();
    check_done();

    // Timeout: valid never arrives.
    vdly = -1;
    start_job();
    run_to_end(5400);
    check_eq("timeout_cyc", to_cyc, last_beat + 4096);
    check_eq("timeout_flag", timeout_o, 1);
    check_eq("timeout_busy", busy_o, 0);
    check_eq("timeout_no_done", ndone, 0);
    vdly = 20;
    do_cycle();
    check_eq("timeout_sticky", timeout_o, 1);
    start_job();
    check_eq("timeout_cleared", timeout_o, 0);
    run_to_end(1400);
    check_stream();
    check_done();

    // Start pulses while busy, plus a stray valid during loading.
    pulse_mode = 1'b1;
    start_job();
    run_to_end(1400);
    pulse_mode = 1'b0;
    check_stream();
    check_done();

    // Reset in the middle of the beat stream, then a fresh job.
    start_job();
    b = 600;
    while (nbeats < 501 && b > 0) begin
      do_cycle();
      b--;
    end
    check_eq("reached_beat_500", nbeats, 501);
    rst_n = 1'b0;
    do_cycle();
    check_all_zero("midjob_reset_outputs");
    rst_n = 1'b1;
    do_cycle();
    check_eq("no_done_after_abort", ndone, 0);
    start_job();
    run_to_end(1400);
    check_stream();
    check_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mlp_load_sequencer.md
# mlp_load_sequencer

Upstream driver for the MLP accelerator top. On `start_i` it resets the accelerator, then streams one inference job from two local SRAMs into the accelerator's load port in the exact beat order the accelerator consumes:
- the 16×16 int16 input matrix, interleaved with layer-0 weights;
- then layers 1–7 weights.

It then watches the 128-beat result window and reports completion or timeout. It replaces the bench-driven load sequence for system integration.

## Interface
- `N_LAYERS`, 8, number of weight layers (layer 0 plus 7 others).
- `ACC_RST_CYC`, 5, cycles `acc_rst_n_o` is held low at job start.
- `RESULT_BEATS`, 128, result beats per job (16 rows × 8 words).
- `TIMEOUT_CYC`, 4096, max cycles from last load beat to first `acc_result_valid_i`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  job start pulse; ignored unless state is IDLE.
- `busy_o`  out  1  high from the cycle after an accepted start until done or timeout.
- `done_o`  out  1  one-cycle pulse when the result window ends.
- `timeout_o`  out  1  sticky error flag; cleared by the next accepted start.
- `in_rd_en_o`  out  1  input SRAM read enable.
- `in_rd_addr_o`  out  7  input SRAM word address = row*8 + k.
- `in_rd_data_i`  in  32  input word; valid the cycle after the address; {elem[2k+1], elem[2k]} of row.
- `w_rd_en_o`  out  1  weight SRAM read enable.
- `w_rd_addr_o`  out  10  weight word address = layer*128 + row*8 + w.
- `w_rd_data_i`  in  32  weight word; 1-cycle read latency; {W[row][2w+1], W[row][2w]}.
- `acc_rst_n_o`  out  1  accelerator synchronous active-low reset.
- `load_en_o`  out  1  beat valid to accelerator.
- `load_payload_o`  out  32  beat data.
- `load_type_o`  out  1  1 = input beat, 0 = weight beat.
- `input_load_number_o`  out  4  row index 0–15.
- `layer_number_o`  out  3  layer 0–7.
- `weight_number_o`  out  3  weight word index 0–7.
- `acc_result_valid_i`  in  1  accelerator result-valid.

## Operation
FSM states:
- **IDLE**
  - Waits for `start_i`.
  - On start: clear `timeout_o`, go to ARST.
- **ARST**
  - Drive `acc_rst_n_o` = 0 for `ACC_RST_CYC` cycles, then go to L0.
- **L0**, for row r = 0..15:
  - 8 input reads (addr r*8+0..7).
  - Then 8 layer-0 weight reads (addr r*8+0..7).
  - 256 reads total.
- **LN**, for layer l = 1..7, row r = 0..15, w = 0..7:
  - Weight read at addr l*128 + r*8 + w.
  - 896 reads total.
- **WAITV**
  - Counts cycles; enters RES on the first cycle `acc_result_valid_i` is sampled high.
  - At `TIMEOUT_CYC` with no valid: set `timeout_o`, go to IDLE, no `done_o`.
- **RES**
  - Counts `RESULT_BEATS` cycles starting the cycle after valid is first sampled.
  - At the end: `done_o` pulse, go to IDLE.

Beat generation:
- Exactly one SRAM read per cycle in L0/LN; no bubbles; 1152 contiguous beats.
- Sideband fields (type, row, layer, w) are pipelined two stages alongside the read so they stay aligned with the data.
- The input/weight mux selects `in_rd_data_i` or `w_rd_data_i` by the delayed type.
- `load_en_o` is high for exactly the 1152 beat cycles and 0 otherwise.
- After the last beat:
  - `weight_number_o` returns to 0.
  - `load_payload_o` returns to 0.
  - `layer_number_o` and `input_load_number_o` hold 7 and 15 until the next job.
- `acc_rst_n_o` returns to 1 after ARST and stays 1 until the next start.

Reset (`rst_n` = 0), including mid-job:
- FSM goes to IDLE; all counters clear.
- All outputs go to 0, including `acc_rst_n_o` (0 until first ARST completes).
- No `done_o` for the aborted job.

## Timing
- Start accepted in cycle S.
  - `acc_rst_n_o` low in cycles S+1..S+5.
  - First read address in S+6.
  - First load beat in S+8.
- Read address to load beat latency: 2 cycles.
  - Cycle 1: SRAM read.
  - Cycle 2: output register.
- Last beat at S+8+1151.
- Layer-0 row r: input beats at offsets 16r..16r+7, weight beats at 16r+8..16r+15.
- Layer l ≥ 1 row r word w: offset 256 + (l−1)*128 + r*8 + w.
- `busy_o` and `done_o`:
  - `busy_o` high S+1 through the `done_o` cycle inclusive.
  - `done_o` asserted in the cycle after the 128th result cycle.
- `start_i` while busy: ignored; no effect on counters or outputs.
- `acc_result_valid_i` high during L0/LN: ignored; only sampled in WAITV.
- `timeout_o` set in WAITV cycle `TIMEOUT_CYC`; `busy_o` falls in the same cycle.

## Test plan
- **Basic job, ordering**
  - Stimulus: SRAM words = address value; start; model asserts valid 20 cycles after last beat.
  - Required:
    - `acc_rst_n_o` low exactly 5 cycles.
    - 1152 beats.
    - beat 0 payload 0, type 1, row 0; beat 8 payload w-addr 0, type 0.
    - beat 256: layer 1, row 0, w 0, payload 128.
    - `done_o` exactly 129 cycles after valid is sampled.
- **Sideband alignment**
  - Stimulus: random SRAM contents.
  - Required: every beat's payload equals the SRAM word at the address implied by its (type, layer, row, w).
- **Timeout**
  - Stimulus: valid never asserted.
  - Required:
    - `timeout_o` = 1 and `busy_o` = 0 at 4096 cycles after the last beat.
    - No `done_o`.
    - Next start clears `timeout_o`.
- **Start while busy**
  - Stimulus: pulse `start_i` at beats 3, 700 and in RES.
  - Required: beat stream and `done_o` timing unchanged.
- **Reset mid-job**
  - Stimulus: `rst_n` low at beat 500, then start.
  - Required:
    - All outputs 0 the cycle after reset.
    - Fresh job restarts from ARST with beat 0 = input row 0.
- **Back-to-back jobs**
  - Stimulus: start the cycle after `done_o`.
  - Required: second job identical timing; `acc_rst_n_o` re-pulses low for 5 cycles.
